fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, which is the instruction buffer entry count (legal 2..8).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1 bit, the fetch request.
REQ-006 SHALL have port imem_req_ready, input, 1 bit, signalling that memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits, the word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit, signalling response data valid; responses return in order, latency ≥1 cycle.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits, the instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit, signalling a branch/jump/trap redirect.
REQ-011 SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-012 SHALL have port inst_valid, output, 1 bit, signalling an instruction available to decode/immediate generation.
REQ-013 SHALL have port inst_ready, input, 1 bit, signalling that the decoder accepts the instruction.
REQ-014 SHALL have port inst, output, 32 bits, the instruction word.
REQ-015 SHALL have port inst_pc, output, 32 bits, the PC of inst.
REQ-016 SHALL have port fetch_misaligned, output, 1 bit, present only under FETCH_MISALIGN_TRAP_EN.

Function
REQ-017 SHALL hold fetch PC register pc_q; imem_req_addr = pc_q; pc_q advances by 4 on each accepted request (valid&ready), wrapping modulo 2^32.
REQ-018 SHALL assert imem_req_valid only when outstanding + buffer_count < DEPTH (credit rule); the buffer SHALL never overflow.
REQ-019 SHALL keep imem_req_valid/addr stable while valid&!ready, except on redirect.
REQ-020 SHALL track outstanding requests (0..DEPTH); a simultaneous accept and response leaves the count unchanged.
REQ-021 SHALL pair each response with its request PC via a PC queue in the buffer; a response is written at the edge and visible on inst/inst_pc the next cycle (1-cycle rsp-to-inst latency).
REQ-022 SHALL make inst_valid = buffer not empty; an entry pops on inst_valid&inst_ready; push and pop in the same cycle are legal, including when full.
REQ-023 SHALL on redirect_valid: flush the buffer, set pc_q = redirect_pc, and load drop_cnt = outstanding (plus 1 if a request is accepted that same cycle).
REQ-024 SHALL discard responses while drop_cnt > 0, decrementing drop_cnt; they SHALL NOT enter the buffer.
REQ-025 SHALL drop a response arriving in the redirect cycle, counting it against drop_cnt.
REQ-026 SHALL treat an entry popped in the redirect cycle (inst_ready=1) as transferred; an unpopped entry is lost.
REQ-027 SHALL deassert imem_req_valid in the redirect cycle; the next cycle SHALL request redirect_pc.
REQ-028 SHALL have a fetch state machine with states RUN and HALT; HALT is used only under FETCH_MISALIGN_TRAP_EN.

Reset
REQ-029 SHALL on rst_n=0 asynchronously set pc_q=RESET_PC, outstanding=0, drop_cnt=0, buffer empty, state RUN.
REQ-030 SHALL on rst_n=0 drive imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0.
REQ-031 SHALL on reset mid-transaction drop all outstanding responses; the memory is reset by the same rst_n.
REQ-032 SHALL issue the first request in the cycle after rst_n deasserts.

Configuration
REQ-033 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on redirect with redirect_pc[1:0]≠0 enter HALT, set fetch_misaligned=1 until the next redirect, flush, and issue no requests; an aligned redirect returns to RUN.
REQ-034 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_pc[1:0] to 2'b00, omit the fetch_misaligned port, and never enter HALT.

Structure
REQ-035 SHALL place XLEN=32, the INST_NOP constant (32'h0000_0013), and the fetch_state_e typedef in shared package core_pkg.
REQ-036 SHALL implement the instruction/PC buffer as sub-module fetch_fifo (parameter DEPTH, with push, pop, flush, full, empty, and count).

Verification
REQ-037 SHALL cover: reset release with RESET_PC=0, ready=1, latency 1 -> requests 0x0,0x4,0x8; inst_pc 0x0,0x4 in order with back-to-back inst_valid.
REQ-038 SHALL cover: inst_ready=0 for 10 cycles -> buffer fills to 2, imem_req_valid=0, no lost/duplicated words on resume.
REQ-039 SHALL cover: 2 requests outstanding, redirect to 0x100 -> both stale responses dropped, next inst_pc=0x100.
REQ-040 SHALL cover: redirect coinciding with imem_rsp_valid and with an inst handshake -> the response is dropped, the popped entry is delivered once.
REQ-041 SHALL cover: pc_q=0xFFFF_FFFC accepted -> next request address 0x0000_0000.
REQ-042 SHALL cover: with the macro, redirect to 0x102 -> fetch_misaligned=1, no requests; redirect to 0x200 -> cleared, fetch 0x200; without the macro -> fetch 0x100.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, canonical NOP and fetch FSM states.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  // Instruction fetch is word granular; the low two address bits are discarded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer between the memory response port and decode.
// Push and pop may occur together, including when full; flush empties it.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; head_data is gated by empty so stale words never leak.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response pairing,
// redirect flush with stale-response dropping. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_state_e    state_q;
  logic            live_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_tgt;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   credit_used;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            inst_fire;
  logic            buf_empty;
  logic            buf_full;
  logic [2*XLEN-1:0] buf_head;

  // Request PCs awaiting their response, oldest at pcq_rd_q.
  logic [XLEN-1:0]  pcq_mem [DEPTH];
  logic [PTR_W-1:0] pcq_wr_q;
  logic [PTR_W-1:0] pcq_rd_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_tgt = align_pc(redirect_pc);
`endif

  // A request is only issued if its response is guaranteed a buffer slot.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = live_q & (state_q == FS_RUN) & ~redirect_valid
                        & (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_drop       = redirect_valid | (drop_cnt_q != '0);
  assign rsp_keep       = imem_rsp_valid & ~rsp_drop;
  assign inst_valid     = ~buf_empty;
  assign inst_fire      = inst_valid & inst_ready;
  assign {inst_pc, inst} = buf_head;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: ;
    endcase
    // Everything still in flight after a redirect belongs to the old path.
    if (redirect_valid)
      drop_cnt_d = outstanding_d;
    else if (imem_rsp_valid && (drop_cnt_q != '0))
      drop_cnt_d = drop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      live_q        <= 1'b1;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (redirect_valid) begin
        pc_q     <= redirect_tgt;
        pcq_wr_q <= '0;
        pcq_rd_q <= '0;
      end else begin
        if (req_fire) begin
          pc_q     <= pc_q + 32'd4;
          pcq_wr_q <= ptr_inc(pcq_wr_q);
        end
        if (rsp_keep) pcq_rd_q <= ptr_inc(pcq_rd_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem[pcq_wr_q] <= pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= FS_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_q          <= FS_HALT;
        fetch_misaligned <= 1'b1;
      end else begin
        state_q          <= FS_RUN;
        fetch_misaligned <= 1'b0;
      end
`else
      state_q <= FS_RUN;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({pcq_mem[pcq_rd_q], imem_rsp_data}),
    .pop       (inst_fire),
    .flush     (redirect_valid),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // A kept response must always find a slot (freed by a same-cycle pop at worst).
  assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && buf_full && !inst_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences
// and a randomized run against a queue-based memory/stream reference model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import core_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
  endfunction

  // Memory model: accepted requests in order, each with the cycle its response is due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  int          cyc = 0;
  int          last_due = 0;
  int          k_ready = 100;
  int          k_iready = 100;
  int          k_lat_min = 1;
  int          k_lat_max = 1;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_inst_pc;
  int          stale_m = 0;
  int          buf_m = 0;
  bit          halted = 1'b0;
  bit          live_m = 1'b0;
  int          n_deliv = 0;
  bit          did_redir, acc_flag, hs_flag;
  logic [31:0] acc_addr, hs_pc;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("rst_misaligned", fetch_misaligned, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    last_due = cyc;
    exp_req_pc = RESET_PC;
    exp_inst_pc = RESET_PC;
    stale_m = 0;
    buf_m = 0;
    halted = 1'b0;
    live_m = 1'b0;
  endtask

  // One clock cycle; mode 0 = no redirect, 1 = redirect, 2 = redirect only if a
  // response and an instruction handshake land in this same cycle.
  task automatic step(input int mode, input logic [31:0] rpc);
    bit rv, ir, redir, pop, keep, acc, exp_rv;
    int lat, due;
    logic [31:0] tgt;
    rv = (mq.size() != 0) && (mq[0].due <= cyc);
    ir = ($urandom_range(99) < k_iready);
    redir = (mode == 1) || ((mode == 2) && rv && inst_valid && ir);
    imem_rsp_valid = rv;
    if (rv) imem_rsp_data = mem_word(mq[0].addr);
    else    imem_rsp_data = '0;
    imem_req_ready = ($urandom_range(99) < k_ready);
    inst_ready = ir;
    redirect_valid = redir;
    redirect_pc = redir ? rpc : $urandom;
    #1;
    exp_rv = live_m && !halted && !redir && ((mq.size() + buf_m) < DEPTH);
    check1("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
    check1("inst_valid", inst_valid, buf_m != 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("misaligned", fetch_misaligned, halted);
`endif
    pop = inst_valid && ir;
    hs_flag = pop;
    hs_pc = inst_pc;
    if (pop) begin
      check("inst_pc", inst_pc, exp_inst_pc);
      check("inst", inst, mem_word(exp_inst_pc));
      exp_inst_pc += 32'd4;
      n_deliv++;
    end
    acc = imem_req_valid && imem_req_ready;
    acc_flag = acc;
    acc_addr = imem_req_addr;
    keep = rv && !redir && (stale_m == 0);
    if (rv) begin
      void'(mq.pop_front());
      if (!redir && stale_m != 0) stale_m--;
    end
    if (acc) begin
      lat = $urandom_range(k_lat_max, k_lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due});
      exp_req_pc += 32'd4;
    end
    if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = rpc;
      halted = (rpc[1:0] != 2'b00);
`else
      tgt = rpc & 32'hFFFF_FFFC;
`endif
      exp_req_pc = tgt;
      exp_inst_pc = tgt;
      stale_m = mq.size();
      buf_m = 0;
    end else begin
      buf_m = buf_m + int'(keep) - int'(pop);
    end
    did_redir = redir;
    live_m = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_acc(input string name, output logic [31:0] addr);
    bit ok = 1'b0;
    addr = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(0, 32'h0);
      if (acc_flag) begin
        ok = 1'b1;
        addr = acc_addr;
      end
    end
    check1({name, "_timeout"}, ok, 1'b1);
  endtask

  task automatic wait_inst(input string name, output logic [31:0] pc);
    bit ok = 1'b0;
    pc = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(0, 32'h0);
      if (hs_flag) begin
        ok = 1'b1;
        pc = hs_pc;
      end
    end
    check1({name, "_timeout"}, ok, 1'b1);
  endtask

  typedef struct {
    logic        ready;
    logic        rsp_v;
    logic [31:0] rsp_a;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[6];
    logic [31:0] a;
    logic [31:0] rpc;
    int          base, r;
    bit          got;

    // Reset release, ready=1, one-cycle latency, decoder always ready.
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h4};
    vecs[5] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'hC, 1'b0, 32'h0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      imem_req_ready = vecs[i].ready;
      imem_rsp_valid = vecs[i].rsp_v;
      imem_rsp_data  = vecs[i].rsp_v ? mem_word(vecs[i].rsp_a) : 32'h0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      #1;
      check1($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      check1($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_inst", i), inst, mem_word(vecs[i].e_pc));
      end
      @(negedge clk);
    end

    // Decoder stalls for 10 cycles: buffer fills, requests stop, then resume.
    do_reset();
    k_ready = 100; k_iready = 100; k_lat_min = 1; k_lat_max = 1;
    repeat (6) step(0, 32'h0);
    k_iready = 0;
    repeat (10) step(0, 32'h0);
    check1("stall_req_off", imem_req_valid, 1'b0);
    check1("stall_inst_held", inst_valid, 1'b1);
    base = n_deliv;
    k_iready = 100;
    repeat (10) step(0, 32'h0);
    check1("stall_resume", (n_deliv - base) >= 4, 1'b1);

    // Two requests in flight, redirect to 0x100: both stale responses dropped.
    do_reset();
    k_lat_min = 4; k_lat_max = 4;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mq.size() == 2) got = 1'b1;
      else step(0, 32'h0);
    end
    check1("two_outstanding", got, 1'b1);
    step(1, 32'h0000_0100);
    wait_inst("redir_first", a);
    check("redir_first_pc", a, 32'h0000_0100);

    // Redirect together with a response and an instruction handshake.
    do_reset();
    k_lat_min = 1; k_lat_max = 1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(2, 32'h0000_0300);
      got = did_redir;
    end
    check1("redir_rsp_hs_hit", got, 1'b1);
    wait_inst("redir_hs_first", a);
    check("redir_hs_first_pc", a, 32'h0000_0300);

    // PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFF8);
    wait_acc("wrap_a", a);
    check("wrap_addr0", a, 32'hFFFF_FFF8);
    wait_acc("wrap_b", a);
    check("wrap_addr1", a, 32'hFFFF_FFFC);
    wait_acc("wrap_c", a);
    check("wrap_addr2", a, 32'h0000_0000);

    // Misaligned redirect target.
    step(1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    base = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 32'h0);
      if (acc_flag) base++;
    end
    check("halt_no_requests", base, 0);
    check1("halt_flag", fetch_misaligned, 1'b1);
    step(1, 32'h0000_0200);
    wait_acc("unhalt", a);
    check("unhalt_addr", a, 32'h0000_0200);
    check1("unhalt_flag", fetch_misaligned, 1'b0);
`else
    wait_acc("misalign", a);
    check("misalign_addr", a, 32'h0000_0100);
`endif

    // Randomized traffic, redirects and a mid-run reset against the model.
    do_reset();
    k_ready = 70; k_iready = 60; k_lat_min = 1; k_lat_max = 4;
    base = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(7) != 0) rpc[1:0] = 2'b00;
`endif
      if (i == 1500) do_reset();
      step((r < 3) ? 1 : ((r < 6) ? 2 : 0), rpc);
    end
    check1("random_progress", (n_deliv - base) > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
